// File: rtl/mmio_store_buffer.sv
// Posts word stores that hit the MMIO window into a small FIFO and drains
// them to a slower peripheral over valid/ready; the processor never stalls.
module mmio_store_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] MMIO_BASE = 32'h0000_0040,
  parameter logic [31:0] MMIO_MASK = 32'hFFFF_FFC0
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_memwrite,
  input  logic [31:0]              i_dataadr,
  input  logic [31:0]              i_writedata,
  output logic                     o_out_valid,
  output logic [31:0]              o_out_addr,
  output logic [31:0]              o_out_data,
  input  logic                     i_out_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic [7:0]               o_drop_count,
  output logic                     o_overflow,
  output logic                     o_misaligned
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   r_addrMem [DEPTH];
  logic [31:0]   r_dataMem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_dropCount;
  logic          r_overflow;
  logic          r_misaligned;

  logic w_inWindow;
  logic w_aligned;
  logic w_capture;
  logic w_misalignedStore;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_inWindow        = (i_dataadr & MMIO_MASK) == MMIO_BASE;
  assign w_aligned         = i_dataadr[1:0] == 2'b00;
  assign w_capture         = i_memwrite && w_inWindow && w_aligned;
  assign w_misalignedStore = i_memwrite && w_inWindow && !w_aligned;
  assign w_full            = r_count == FULL_COUNT;
  assign w_pop             = (r_count != '0) && i_out_ready;
  // A pop on the same edge frees the slot, so a full buffer can still accept.
  assign w_push            = w_capture && (!w_full || w_pop);
  assign w_drop            = w_capture && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addrMem[i] <= '0;
        r_dataMem[i] <= '0;
      end
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_dropCount  <= '0;
      r_overflow   <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      if (w_push) begin
        r_addrMem[r_wrPtr] <= i_dataadr;
        r_dataMem[r_wrPtr] <= i_writedata;
        r_wrPtr            <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropCount != 8'hFF) begin
          r_dropCount <= r_dropCount + 8'd1;
        end
      end
      if (w_misalignedStore) begin
        r_misaligned <= 1'b1;
      end
    end
  end

  // Head is shown straight from storage; stale contents when empty.
  assign o_out_valid  = r_count != '0;
  assign o_out_addr   = r_addrMem[r_rdPtr];
  assign o_out_data   = r_dataMem[r_rdPtr];
  assign o_count      = r_count;
  assign o_full       = w_full;
  assign o_drop_count = r_dropCount;
  assign o_overflow   = r_overflow;
  assign o_misaligned = r_misaligned;

endmodule

// File: tb/tb_mmio_store_buffer.sv
// Bench for mmio_store_buffer: directed plan steps plus random traffic,
// all compared against a queue-based model of the posting buffer.
module tb_mmio_store_buffer;

  localparam int          DEPTH     = 4;
  localparam logic [31:0] MMIO_BASE = 32'h0000_0040;
  localparam logic [31:0] MMIO_MASK = 32'hFFFF_FFC0;

  logic        i_clk;
  logic        i_reset;
  logic        i_memwrite;
  logic [31:0] i_dataadr;
  logic [31:0] i_writedata;
  logic        o_out_valid;
  logic [31:0] o_out_addr;
  logic [31:0] o_out_data;
  logic        i_out_ready;
  logic [2:0]  o_count;
  logic        o_full;
  logic [7:0]  o_drop_count;
  logic        o_overflow;
  logic        o_misaligned;

  mmio_store_buffer #(
    .DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE), .MMIO_MASK(MMIO_MASK)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_memwrite(i_memwrite),
    .i_dataadr(i_dataadr), .i_writedata(i_writedata),
    .o_out_valid(o_out_valid), .o_out_addr(o_out_addr), .o_out_data(o_out_data),
    .i_out_ready(i_out_ready), .o_count(o_count), .o_full(o_full),
    .o_drop_count(o_drop_count), .o_overflow(o_overflow), .o_misaligned(o_misaligned)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } entry_t;

  entry_t      mq[$];
  int          mDrops;
  bit          mOvf;
  bit          mMis;
  logic [31:0] popAddr[$];
  logic [31:0] popData[$];
  int          compared;
  int          mismatched;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock step: the model follows the buffer rules (pop frees a slot
  // before the store is considered), and DUT pops are logged for order checks.
  task automatic applyStimulus(input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic rdy,
                               input logic rst);
    entry_t e;
    i_memwrite  = we;
    i_dataadr   = adr;
    i_writedata = dat;
    i_out_ready = rdy;
    i_reset     = rst;
    if (rst) begin
      mq.delete();
      mDrops = 0;
      mOvf   = 1'b0;
      mMis   = 1'b0;
    end else begin
      if (o_out_valid && rdy) begin
        popAddr.push_back(o_out_addr);
        popData.push_back(o_out_data);
      end
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (we && ((adr & MMIO_MASK) == MMIO_BASE)) begin
        if (adr[1:0] != 2'b00) mMis = 1'b1;
        else if (mq.size() < DEPTH) begin
          e.a = adr;
          e.d = dat;
          mq.push_back(e);
        end else begin
          mOvf = 1'b1;
          if (mDrops < 255) mDrops++;
        end
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".valid"}, 32'(o_out_valid), 32'(mq.size() != 0));
    check({tag, ".count"}, 32'(o_count), 32'(mq.size()));
    check({tag, ".full"}, 32'(o_full), 32'(mq.size() == DEPTH));
    check({tag, ".drops"}, 32'(o_drop_count), 32'(mDrops));
    check({tag, ".ovf"}, 32'(o_overflow), 32'(mOvf));
    check({tag, ".mis"}, 32'(o_misaligned), 32'(mMis));
    if (mq.size() != 0) begin
      check({tag, ".addr"}, o_out_addr, mq[0].a);
      check({tag, ".data"}, o_out_data, mq[0].d);
    end
  endtask

  task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic rdy, input logic rst, input string tag);
    applyStimulus(we, adr, dat, rdy, rst);
    checkOutput(tag);
  endtask

  initial begin
    logic [31:0] adr;
    compared   = 0;
    mismatched = 0;
    i_reset = 1'b1; i_memwrite = 1'b0; i_dataadr = '0; i_writedata = '0; i_out_ready = 1'b0;
    mDrops = 0; mOvf = 1'b0; mMis = 1'b0;

    // Basic post
    step(0, 0, 0, 0, 1, "reset0");
    step(0, 0, 0, 0, 1, "reset1");
    check("resetAddrKnown", 32'($isunknown(o_out_addr)), 32'd0);
    check("resetValid", 32'(o_out_valid), 32'd0);
    step(1, 32'd80, 32'd7, 0, 0, "post");
    check("postValid", 32'(o_out_valid), 32'd1);
    check("postAddr", o_out_addr, 32'd80);
    check("postData", o_out_data, 32'd7);
    check("postCount", 32'(o_count), 32'd1);
    step(0, 0, 0, 1, 0, "postPop");
    check("postPopCount", 32'(o_count), 32'd0);
    check("postPopValid", 32'(o_out_valid), 32'd0);

    // Filter: out-of-window and misaligned stores
    step(1, 32'd0, 32'd1, 0, 0, "filt0");
    step(1, 32'h0000_0100, 32'd2, 0, 0, "filt100");
    step(1, 32'd84, 32'd3, 0, 0, "filt84");
    check("filtCount", 32'(o_count), 32'd1);
    check("filtAddr", o_out_addr, 32'd84);
    step(1, 32'd82, 32'd4, 0, 0, "filt82");
    check("misSet", 32'(o_misaligned), 32'd1);
    check("misCount", 32'(o_count), 32'd1);
    check("misDrops", 32'(o_drop_count), 32'd0);
    step(0, 0, 0, 1, 0, "filtDrain");

    // Overflow: six stores into a four-entry buffer
    for (int i = 0; i < 6; i++) step(1, 32'(64 + 4 * i), 32'(100 + i), 0, 0, "ovf");
    check("ovfFull", 32'(o_full), 32'd1);
    check("ovfDrops", 32'(o_drop_count), 32'd2);
    check("ovfFlag", 32'(o_overflow), 32'd1);
    popAddr.delete(); popData.delete();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, "ovfDrain");
    check("ovfDrainN", 32'(popAddr.size()), 32'd4);
    for (int i = 0; i < 4 && i < popAddr.size(); i++) check("ovfOrder", popAddr[i], 32'(64 + 4 * i));

    // Full plus simultaneous pop
    for (int i = 0; i < 4; i++) step(1, 32'(64 + 4 * i), 32'(200 + i), 0, 0, "fill");
    popAddr.delete(); popData.delete();
    step(1, 32'd88, 32'd204, 1, 0, "fullPop");
    check("fullPopCount", 32'(o_count), 32'd4);
    check("fullPopDrops", 32'(o_drop_count), 32'd2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, "fullPopDrain");
    check("fullPopN", 32'(popAddr.size()), 32'd5);
    if (popAddr.size() > 0) check("fullPopLast", popAddr[popAddr.size() - 1], 32'd88);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) step(1, 32'(72 + 4 * i), 32'(300 + i), 0, 0, "rq");
    step(0, 0, 0, 1, 1, "rstMid");
    check("rstCount", 32'(o_count), 32'd0);
    check("rstValid", 32'(o_out_valid), 32'd0);
    check("rstDrops", 32'(o_drop_count), 32'd0);
    check("rstOvf", 32'(o_overflow), 32'd0);
    check("rstMis", 32'(o_misaligned), 32'd0);

    // Streaming with wrap-around
    popAddr.delete(); popData.delete();
    for (int i = 1; i <= 20; i++) step(1, 32'(64 + 4 * (i % 16)), 32'(i), 1, 0, "stream");
    step(0, 0, 0, 1, 0, "streamTail");
    check("streamN", 32'(popData.size()), 32'd20);
    for (int i = 0; i < 20 && i < popData.size(); i++) check("streamOrder", popData[i], 32'(i + 1));
    check("streamDrops", 32'(o_drop_count), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        7:       adr = MMIO_BASE | 32'($urandom_range(0, 63));
        8:       adr = $urandom;
        default: adr = MMIO_BASE | 32'($urandom_range(0, 15) << 2);
      endcase
      step($urandom_range(0, 3) != 0, adr, $urandom, $urandom_range(0, 1) == 1, 0, "rand");
    end

    // Drop counter saturation
    step(0, 0, 0, 0, 1, "satReset");
    for (int i = 0; i < 262; i++) applyStimulus(1, 32'd64, 32'(i), 0, 0);
    checkOutput("sat");
    check("satDrops", 32'(o_drop_count), 32'd255);
    check("satOvf", 32'(o_overflow), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mmio_store_buffer.md
# mmio_store_buffer

Write-posting buffer downstream of the MIPS `top` data-memory write port. Captures word stores (`memwrite`, `dataadr`, `writedata`) that fall in a memory-mapped I/O window into a small FIFO and drains them to a slower peripheral over a valid/ready handshake. The processor is never stalled: stores that arrive while the buffer is full are dropped, counted and flagged. Stores outside the window pass untouched to data memory and are ignored here.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `MMIO_BASE`, 32'h0000_0040: window base address.
- `MMIO_MASK`, 32'hFFFF_FFC0: address is in the window when `(dataadr & MMIO_MASK) == MMIO_BASE`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `memwrite`  in  1  store strobe from `top`, valid for the whole cycle.
- `dataadr`  in  32  store byte address.
- `writedata`  in  32  store data.
- `out_valid`  out  1  head entry available.
- `out_addr`  out  32  head entry address.
- `out_data`  out  32  head entry data.
- `out_ready`  in  1  peripheral accepts head entry.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `full`  out  1  `count == DEPTH`.
- `drop_count`  out  8  dropped in-window stores; saturates at 255.
- `overflow`  out  1  sticky: at least one store dropped since reset.
- `misaligned`  out  1  sticky: in-window store with `dataadr[1:0] != 0` seen since reset.

## Operation
- Capture condition: `memwrite` high, address in window, `dataadr[1:0] == 0`.
- In-window store with `dataadr[1:0] != 0`: not captured, not counted as a drop, sets `misaligned`.
- Pop: `out_valid && out_ready` at a rising edge removes the head.
- Push: a captured store is written at the tail when `count < DEPTH`, or when `count == DEPTH` and a pop occurs on the same edge. Pop frees the slot first, so the store is accepted and `count` stays at `DEPTH`.
- Drop: a captured store with `count == DEPTH` and no pop on that edge is discarded. `drop_count` increments, saturating at 255, and `overflow` is set.
- Push and pop on the same edge with `0 < count < DEPTH`: both occur and `count` is unchanged.
- Push on an empty buffer: entry is stored. There is no bypass, so `out_valid` stays low in that same cycle.
- Storage: circular buffer with read and write pointers of width `$clog2(DEPTH)` that wrap modulo `DEPTH`. `count` is tracked separately.
- Output: first-word-fall-through. `out_valid = (count != 0)`. `out_addr`/`out_data` show the head entry combinationally from registers. When `out_valid` is low these outputs are don't-care but must not be X after reset; drive the stale register contents.
- Peripheral side: must hold `out_ready` independent of `out_valid`. The block keeps the head stable until it is popped.

## Timing
- Reset values: `out_valid`=0, `count`=0, `full`=0, `drop_count`=0, `overflow`=0, `misaligned`=0, pointers=0, storage=0.
- Reset has priority over push and pop on the same edge. Reset in the middle of a drain flushes every entry, and `out_valid` is low from the next cycle on.
- Latency: a store accepted at edge N shows `out_valid`=1 with its address and data in the cycle after edge N, when the buffer was empty.
- Throughput: one push and one pop per cycle; sustained 1 store/cycle with `out_ready` held high gives no drops.
- `full`, `count` and the sticky flags update only at rising edges. No combinational path from `memwrite` to any output.

## Test plan
- Basic post: reset for 2 cycles, then store `dataadr`=80, `writedata`=7 with `out_ready`=0 -> next cycle `out_valid`=1, `out_addr`=80, `out_data`=7, `count`=1. Raise `out_ready` for one cycle -> `count`=0, `out_valid`=0.
- Filter: stores to 0, 32'h0000_0100 and 84 -> only 84 is captured, `count`=1. A store to 82 -> `misaligned`=1, `count` unchanged, `drop_count`=0.
- Overflow: `out_ready`=0, six stores to 64,68,72,76,80,84 with DEPTH=4 -> `full`=1, `drop_count`=2, `overflow`=1. Drain shows addresses 64,68,72,76 in order.
- Full plus simultaneous pop: fill to 4 entries, then a store to 88 with `out_ready`=1 on the same edge -> accepted, `count`=4, `drop_count` unchanged, and 88 is the last entry out.
- Wrap-around and streaming: 20 back-to-back stores with data 1..20 and `out_ready`=1 -> output sequence 1..20 in order, no drops, pointers wrap at least 4 times.
- Reset mid-drain: 3 entries queued, `reset` asserted for 1 cycle while `out_ready`=1 -> next cycle `count`=0, `out_valid`=0, `drop_count`=0, sticky flags cleared.
